letter_display_scanner: RTL

//  Time-multiplexes a NUM_DIGITS-letter word onto a common-segment seven-segment display.

---
 rtl/letter_display_scanner_pkg.sv | 28 ++
 rtl/letter_display_scanner_if.sv | 42 ++++
 rtl/letter_display_scanner_refresh_divider.sv | 31 +++
 rtl/letter_display_scanner.sv | 121 ++++++++++++
 4 files changed

// File: rtl/letter_display_scanner_pkg.sv
// Shared constants for the letter display scanner.
// Letter codes, blank code, default guard time, width helper.
package letter_display_pkg;

   typedef enum logic [3:0] {
      LTR_0     = 4'h0,
      LTR_1     = 4'h1,
      LTR_2     = 4'h2,
      LTR_3     = 4'h3,
      LTR_4     = 4'h4,
      LTR_5     = 4'h5,
      LTR_6     = 4'h6,
      LTR_7     = 4'h7,
      LTR_BLANK = 4'hF
   } letter_e;

   localparam logic [3:0] BLANK_CODE = LTR_BLANK;
   localparam int DEAD_CYC_DEF = 2;

   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/letter_display_scanner_if.sv
// Word load / display bus of the letter display scanner.
// blink_mask exists only when LDS_BLINK_EN is defined.
interface letter_display_scanner_if #(
   parameter int NUM_DIGITS = 4,
   parameter int CODE_W     = 4
);

   logic                         word_load;
   logic [NUM_DIGITS*CODE_W-1:0] word_in;
   logic                         load_ack;
   logic [CODE_W-1:0]            letter_code;
   logic [NUM_DIGITS-1:0]        an_out;
   logic                         frame_tick;
`ifdef LDS_BLINK_EN
   logic [NUM_DIGITS-1:0]        blink_mask;
`endif

   modport master (
      output word_load,
      output word_in,
`ifdef LDS_BLINK_EN
      output blink_mask,
`endif
      input  load_ack,
      input  letter_code,
      input  an_out,
      input  frame_tick
   );

   modport slave (
      input  word_load,
      input  word_in,
`ifdef LDS_BLINK_EN
      input  blink_mask,
`endif
      output load_ack,
      output letter_code,
      output an_out,
      output frame_tick
   );

endinterface

// File: rtl/letter_display_scanner_refresh_divider.sv
// Digit slot divider: counts clocks within a slot.
// slot_tick marks the last clock, in_dead the anode guard time.
module refresh_divider
   import letter_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYC    = DEAD_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic slot_tick,
   output logic in_dead
);

   localparam int CNT_W = clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_N  = CNT_W'(DEAD_CYC);

   logic [CNT_W-1:0] cnt;

   assign slot_tick = (cnt == CNT_MAX);
   assign in_dead   = (cnt < DEAD_N);

   // free-running slot counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            cnt <= '0;
      else if (slot_tick) cnt <= '0;
      else                cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/letter_display_scanner.sv
// Multiplexes a double-buffered word onto active-low digit anodes.
// Optional LDS_BLINK_EN adds per-digit blinking via blink_mask.
module letter_display_scanner
   import letter_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CODE_W       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int DEAD_CYC     = DEAD_CYC_DEF
`ifdef LDS_BLINK_EN
   ,parameter int BLINK_FRAMES = 64
`endif
) (
   input logic                 clk,
   input logic                 rst,
   letter_display_scanner_if.slave bus
);

   localparam int IDX_W  = clog2(NUM_DIGITS);
   localparam int WORD_W = NUM_DIGITS * CODE_W;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CODE_W-1:0] BLANK    = CODE_W'(BLANK_CODE);

   logic              slot_tick;
   logic              in_dead;
   logic              fb;
   logic              vis;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] active_word;
   logic [WORD_W-1:0] shadow_word;
   logic              pending;

   logic [CODE_W-1:0]     code_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  tick_q;
   logic                  ack_q;

   refresh_divider #(
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYC    (DEAD_CYC)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .slot_tick (slot_tick),
      .in_dead   (in_dead)
   );

   assign fb = slot_tick && (idx == LAST_IDX);

   // digit index advances once per slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            idx <= '0;
      else if (slot_tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
   end

   // double buffer: new words land in active only at a frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_word <= {NUM_DIGITS{BLANK}};
         shadow_word <= {NUM_DIGITS{BLANK}};
         pending     <= 1'b0;
      end else if (fb && bus.word_load) begin
         active_word <= bus.word_in;
         pending     <= 1'b0;
      end else if (fb && pending) begin
         active_word <= shadow_word;
         pending     <= 1'b0;
      end else if (bus.word_load) begin
         shadow_word <= bus.word_in;
         pending     <= 1'b1;
      end
   end

`ifdef LDS_BLINK_EN
   localparam int FRM_W = clog2(BLINK_FRAMES);
   localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

   logic [FRM_W-1:0] frm_cnt;
   logic             phase;

   // blink phase flips every BLINK_FRAMES frames, starts visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_cnt <= '0;
         phase   <= 1'b0;
      end else if (fb) begin
         if (frm_cnt == FRM_MAX) begin
            frm_cnt <= '0;
            phase   <= ~phase;
         end else begin
            frm_cnt <= frm_cnt + 1'b1;
         end
      end
   end

   assign vis = !(phase && bus.blink_mask[idx]);
`else
   assign vis = 1'b1;
`endif

   // registered outputs, one clock behind the scan state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q <= BLANK;
         an_q   <= '1;
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         code_q <= vis ? active_word[idx*CODE_W +: CODE_W] : BLANK;
         an_q   <= (in_dead || !vis) ? '1 : ~(NUM_DIGITS'(1) << idx);
         tick_q <= fb;
         ack_q  <= fb && (pending || bus.word_load);
      end
   end

   assign bus.letter_code = code_q;
   assign bus.an_out      = an_q;
   assign bus.frame_tick  = tick_q;
   assign bus.load_ack    = ack_q;

endmodule
